// File: rtl/pause_seq_pkg.sv
// Shared types and constants for the pause sequencer: FSM state encoding,
// requester limit, timeout counter width and a saturating increment helper.
package pause_seq_pkg;

    localparam int MAX_NREQ = 8;
    localparam int CNT_W    = 32;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_ARM    = 3'd1,
        ST_HALT   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_RESUME = 3'd4,
        ST_STEP   = 3'd5
    } pause_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/pause_vbl_edge.sv
// Vertical-blank rising-edge detector. With SYNC_VBL=0 the edge output is
// forced high so the sequencer acts on the very next clock.
module pause_vbl_edge #(
    parameter int SYNC_VBL = 1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic vblank,
    output logic vbl_rise
);

    logic vblank_q_r;

    // Previous-cycle copy of vblank for edge detection
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vblank_q_r <= 1'b0;
        end else begin
            vblank_q_r <= vblank;
        end
    end

    assign vbl_rise = (SYNC_VBL != 0) ? (vblank & ~vblank_q_r) : 1'b1;

endmodule

// File: rtl/pause_sequencer.sv
// Pause request arbiter: halts the CPU at frame boundaries, waits for the
// halt acknowledge (or a timeout), then grants requesters. Define
// PAUSE_SEQ_STEP_EN to enable single-frame stepping from PAUSED.
module pause_sequencer
    import pause_seq_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int ACK_TIMEOUT = 4096,
    parameter int SYNC_VBL    = 1
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    input  logic            vblank,
    input  logic            cpu_halt_ack,
    input  logic            step,
    output logic            pause_cpu,
    output logic            paused,
    output logic            timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    if ((NREQ < 1) || (NREQ > MAX_NREQ)) begin : g_bad_nreq
        $error("pause_sequencer: NREQ out of range");
    end

    pause_state_e    state_r;
    pause_state_e    state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] gnt_nxt_s;
    logic            pause_cpu_r;
    logic            pause_cpu_nxt_s;
    logic            paused_r;
    logic            paused_nxt_s;
    logic            timeout_err_r;
    logic            timeout_nxt_s;
    logic            any_req_s;
    logic            vbl_rise_s;

`ifndef PAUSE_SEQ_STEP_EN
    logic            unused_step_s;
    assign unused_step_s = step;
`endif

    assign any_req_s = |req;

    pause_vbl_edge #(
        .SYNC_VBL (SYNC_VBL)
    ) u_vbl_edge (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vblank   (vblank),
        .vbl_rise (vbl_rise_s)
    );

    // Next-state, timeout counter and registered-output computation
    always_comb begin
        state_nxt_s     = state_r;
        timeout_nxt_s   = timeout_err_r;
        cnt_nxt_s       = cnt_r;
        gnt_nxt_s       = {NREQ{1'b0}};
        pause_cpu_nxt_s = 1'b0;
        paused_nxt_s    = 1'b0;

        case (state_r)
            ST_RUN: begin
                if (any_req_s) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ARM: begin
                if (!any_req_s) begin
                    state_nxt_s = ST_RUN;
                end else if (vbl_rise_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_HALT: begin
                // Ack beats a coincident timeout; a withdrawn request still waits for vblank
                if (!any_req_s) begin
                    state_nxt_s = ST_RESUME;
                end else if (cpu_halt_ack) begin
                    state_nxt_s = ST_PAUSED;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s   = ST_PAUSED;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_PAUSED: begin
                if (!any_req_s) begin
                    state_nxt_s = ST_RESUME;
                end
`ifdef PAUSE_SEQ_STEP_EN
                else if (step) begin
                    state_nxt_s = ST_STEP;
                end
`endif
                else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            ST_RESUME: begin
                if (any_req_s) begin
                    state_nxt_s = ST_PAUSED;
                end else if (vbl_rise_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_RESUME;
                end
            end
`ifdef PAUSE_SEQ_STEP_EN
            ST_STEP: begin
                if (!any_req_s) begin
                    state_nxt_s = ST_RUN;
                end else if (vbl_rise_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase

        if ((state_nxt_s == ST_HALT) && (state_r != ST_HALT)) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (state_r == ST_HALT) begin
            cnt_nxt_s = sat_inc(cnt_r);
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // Grants follow req only while halted; STEP keeps grants but drops released ones
        case (state_nxt_s)
            ST_PAUSED: gnt_nxt_s = req;
            ST_STEP:   gnt_nxt_s = gnt_r & req;
            default:   gnt_nxt_s = {NREQ{1'b0}};
        endcase

        pause_cpu_nxt_s = (state_nxt_s == ST_HALT) || (state_nxt_s == ST_PAUSED) ||
                          (state_nxt_s == ST_RESUME);
        paused_nxt_s    = (state_nxt_s == ST_PAUSED);
    end

    // State and output registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r       <= ST_RUN;
            cnt_r         <= {CNT_W{1'b0}};
            gnt_r         <= {NREQ{1'b0}};
            pause_cpu_r   <= 1'b0;
            paused_r      <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            gnt_r         <= gnt_nxt_s;
            pause_cpu_r   <= pause_cpu_nxt_s;
            paused_r      <= paused_nxt_s;
            timeout_err_r <= timeout_nxt_s;
        end
    end

    assign gnt         = gnt_r;
    assign pause_cpu   = pause_cpu_r;
    assign paused      = paused_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_pause_sequencer.sv
// Directed bench for pause_sequencer (ACK_TIMEOUT=16) plus a SYNC_VBL=0
// instance; step checks follow PAUSE_SEQ_STEP_EN.
module tb_pause_sequencer;

    logic       clk_sys;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       vblank;
    logic       cpu_halt_ack;
    logic       step;
    logic       pause_cpu;
    logic       paused;
    logic       timeout_err;

    logic [3:0] req_b;
    logic [3:0] gnt_b;
    logic       pause_cpu_b;
    logic       paused_b;
    logic       timeout_err_b;

    int n_checks;
    int n_pass;

    pause_sequencer #(.NREQ(4), .ACK_TIMEOUT(16), .SYNC_VBL(1)) u_dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req          (req),
        .gnt          (gnt),
        .vblank       (vblank),
        .cpu_halt_ack (cpu_halt_ack),
        .step         (step),
        .pause_cpu    (pause_cpu),
        .paused       (paused),
        .timeout_err  (timeout_err)
    );

    pause_sequencer #(.NREQ(4), .ACK_TIMEOUT(16), .SYNC_VBL(0)) u_dut_imm (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req          (req_b),
        .gnt          (gnt_b),
        .vblank       (1'b0),
        .cpu_halt_ack (1'b0),
        .step         (1'b0),
        .pause_cpu    (pause_cpu_b),
        .paused       (paused_b),
        .timeout_err  (timeout_err_b)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // RUN -> ARM -> HALT (vblank pulse) -> PAUSED (ack)
    task automatic enter_pause(input logic [3:0] mask);
        req = mask;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        cpu_halt_ack = 1'b1;
        tick();
        cpu_halt_ack = 1'b0;
    endtask

    task automatic release_all();
        req = 4'b0000;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        req          = 4'b0000;
        req_b        = 4'b0000;
        vblank       = 1'b0;
        cpu_halt_ack = 1'b0;
        step         = 1'b0;
        tick_n(2);
        check("rst_pause_cpu", {31'd0, pause_cpu}, 32'd0);
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: request mid-frame, halt at vblank, ack 3 cycles later
        req = 4'b0001;
        tick_n(3);
        check("t1_wait_vbl", {31'd0, pause_cpu}, 32'd0);
        vblank = 1'b1;
        tick();
        check("t1_pause_cpu", {31'd0, pause_cpu}, 32'd1);
        vblank = 1'b0;
        tick_n(3);
        check("t1_gnt_before_ack", {28'd0, gnt}, 32'd0);
        cpu_halt_ack = 1'b1;
        tick();
        cpu_halt_ack = 1'b0;
        check("t1_gnt", {28'd0, gnt}, 32'h1);
        check("t1_paused", {31'd0, paused}, 32'd1);
        check("t1_no_timeout", {31'd0, timeout_err}, 32'd0);
        req = 4'b0011;
        tick();
        check("t1_gnt_follow", {28'd0, gnt}, 32'h3);
        req = 4'b0001;
        tick();
        check("t1_gnt_drop", {28'd0, gnt}, 32'h1);

        // step: ignored unless the stepping feature is built in
        step = 1'b1;
        tick();
        step = 1'b0;
`ifdef PAUSE_SEQ_STEP_EN
        check("t6_step_cpu", {31'd0, pause_cpu}, 32'd0);
        check("t6_step_gnt", {28'd0, gnt}, 32'h1);
        tick_n(5);
        check("t6_step_run", {31'd0, pause_cpu}, 32'd0);
        check("t6_step_gnt_held", {28'd0, gnt}, 32'h1);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        check("t6_rehalt", {31'd0, pause_cpu}, 32'd1);
        cpu_halt_ack = 1'b1;
        tick();
        cpu_halt_ack = 1'b0;
        check("t6_repaused_gnt", {28'd0, gnt}, 32'h1);
`else
        check("t6_step_ignored", {31'd0, paused}, 32'd1);
        check("t6_step_cpu_held", {31'd0, pause_cpu}, 32'd1);
`endif

        // 2: request dropped, release waits for vblank
        req = 4'b0000;
        tick();
        check("t2_gnt_clear", {28'd0, gnt}, 32'd0);
        check("t2_paused_clear", {31'd0, paused}, 32'd0);
        tick_n(199);
        check("t2_still_halted", {31'd0, pause_cpu}, 32'd1);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        check("t2_released", {31'd0, pause_cpu}, 32'd0);
        tick();

        // ARM with request dropped on the vblank edge -> back to RUN
        req = 4'b0001;
        tick();
        req = 4'b0000;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick_n(2);
        check("arm_drop", {31'd0, pause_cpu}, 32'd0);

        // 4: swap requester during RESUME, no release
        enter_pause(4'b0100);
        check("t4_gnt_first", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        tick();
        check("t4_resume_cpu", {31'd0, pause_cpu}, 32'd1);
        check("t4_resume_gnt", {28'd0, gnt}, 32'd0);
        req = 4'b0010;
        tick();
        check("t4_gnt_second", {28'd0, gnt}, 32'h2);
        check("t4_cpu_held", {31'd0, pause_cpu}, 32'd1);
        release_all();

        // 3: ack never arrives, timeout after 16 HALT cycles
        req = 4'b1000;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick_n(15);
        check("t3_before_timeout", {31'd0, paused}, 32'd0);
        tick();
        check("t3_paused", {31'd0, paused}, 32'd1);
        check("t3_timeout_err", {31'd0, timeout_err}, 32'd1);
        check("t3_gnt", {28'd0, gnt}, 32'h8);
        release_all();
        check("t3_sticky", {31'd0, timeout_err}, 32'd1);

        // 5: async reset in HALT
        req = 4'b0001;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick_n(2);
        check("t5_in_halt", {31'd0, pause_cpu}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_cpu", {31'd0, pause_cpu}, 32'd0);
        check("t5_rst_timeout", {31'd0, timeout_err}, 32'd0);
        check("t5_rst_gnt", {28'd0, gnt}, 32'd0);
        #1 reset = 1'b0;
        req = 4'b0000;
        tick();

        // ack coincident with the last timeout cycle: ack wins
        req = 4'b0001;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick_n(15);
        cpu_halt_ack = 1'b1;
        tick();
        cpu_halt_ack = 1'b0;
        check("ack_wins_paused", {31'd0, paused}, 32'd1);
        check("ack_wins_no_err", {31'd0, timeout_err}, 32'd0);
        release_all();

        // SYNC_VBL=0 instance acts without vblank
        req_b = 4'b0001;
        tick();
        check("imm_arm", {31'd0, pause_cpu_b}, 32'd0);
        tick();
        check("imm_halt", {31'd0, pause_cpu_b}, 32'd1);
        req_b = 4'b0000;
        tick();
        check("imm_resume", {31'd0, pause_cpu_b}, 32'd1);
        tick();
        check("imm_release", {31'd0, pause_cpu_b}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
